stage4_memory_access: RTL and testbench

- Pipeline stage 4 (MEM). Consumes the registered EX outputs: ALU result, store data, memory/writeback controls, destination register, CALL/RET flags.
- Performs data-memory loads and stores. Owns the stack pointer and pushes/pops return addresses for CALL/RET.
- Registers everything into the MEM/WB pipeline boundary for Stage5 writeback.

---
 rtl/stage4_memory_access.sv | 145 ++++++++++++++
 tb/tb_stage4_memory_access.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stage4_memory_access.sv
// Pipeline stage 4 (MEM): data-memory load/store, CALL/RET stack handling and
// the MEM/WB pipeline register feeding writeback.
module stage4_memory_access #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DEPTH   = 256,
    parameter logic [ADDR_W-1:0] SP_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Result_in,
    input  logic [DATA_W-1:0] data1_in,
    input  logic              Memory_Read_in,
    input  logic              Memory_Write_in,
    input  logic              Reg_Write_En_in,
    input  logic              WB_Mux_sel_in,
    input  logic [4:0]        Addr_Write_Reg_in,
    input  logic              CALL_flag_in,
    input  logic              RET_flag_in,
    input  logic [ADDR_W-1:0] Ret_Addr_in,
    output logic [DATA_W-1:0] Mem_Data_out,
    output logic [DATA_W-1:0] Result_out,
    output logic              Reg_Write_En_out,
    output logic              WB_Mux_sel_out,
    output logic [4:0]        Addr_Write_Reg_out,
    output logic [ADDR_W-1:0] Ret_Addr_out,
    output logic              Ret_Valid_out,
    output logic [ADDR_W-1:0] SP_out,
    output logic              Stack_Err_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_PUSH, ST_POP} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] result_q;
    logic              rwe_q, wbsel_q;
    logic [4:0]        awr_q;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              err_q, err_d;
    logic              ret_valid;

    logic [ADDR_W-1:0] addr, sp_inc, mem_waddr;
    logic [DATA_W-1:0] mem_wdata, rd_word;
    logic              do_push, do_pop, do_store, do_load, underflow, mem_we;

    assign addr   = Result_in[ADDR_W-1:0];
    assign sp_inc = sp_q + ADDR_W'(1);

    // Fixed priority CALL > RET > store > load; losers are dropped.
    always_comb begin
        do_push   = CALL_flag_in;
        do_pop    = RET_flag_in & ~CALL_flag_in;
        do_store  = Memory_Write_in & ~CALL_flag_in & ~RET_flag_in;
        do_load   = Memory_Read_in & ~Memory_Write_in & ~CALL_flag_in & ~RET_flag_in;
        underflow = do_pop && (sp_q == SP_INIT);
    end

    always_comb begin
        mem_we    = reset & (do_push | do_store);
        mem_waddr = do_push ? sp_q : addr;
        mem_wdata = do_push ? {{(DATA_W-ADDR_W){1'b0}}, Ret_Addr_in} : data1_in;
        rd_word   = mem[do_pop ? sp_inc : addr];
    end

    always_comb begin
        sp_d       = sp_q;
        err_d      = err_q;
        mem_data_d = mem_data_q;
        ret_addr_d = ret_addr_q;
        if (do_push) begin
            sp_d  = sp_q - ADDR_W'(1);
            err_d = err_q | (sp_q == '0);
        end else if (do_pop) begin
            if (underflow) begin
                err_d      = 1'b1;
                mem_data_d = '0;
                ret_addr_d = '0;
            end else begin
                sp_d       = sp_inc;
                mem_data_d = rd_word;
                ret_addr_d = rd_word[ADDR_W-1:0];
            end
        end else if (do_load) begin
            mem_data_d = rd_word;
        end
    end

    // Memory is deliberately outside the reset domain; reset only gates writes.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_data_q <= '0;
            result_q   <= '0;
            rwe_q      <= 1'b0;
            wbsel_q    <= 1'b0;
            awr_q      <= '0;
            ret_addr_q <= '0;
            sp_q       <= SP_INIT;
            err_q      <= 1'b0;
        end else begin
            mem_data_q <= mem_data_d;
            result_q   <= Result_in;
            rwe_q      <= Reg_Write_En_in;
            wbsel_q    <= WB_Mux_sel_in;
            awr_q      <= Addr_Write_Reg_in;
            ret_addr_q <= ret_addr_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        if (do_push)     state_d = ST_PUSH;
        else if (do_pop) state_d = ST_POP;
    end

    always_comb begin
        ret_valid = (state_q == ST_POP);
    end

    assign Mem_Data_out       = mem_data_q;
    assign Result_out         = result_q;
    assign Reg_Write_En_out   = rwe_q;
    assign WB_Mux_sel_out     = wbsel_q;
    assign Addr_Write_Reg_out = awr_q;
    assign Ret_Addr_out       = ret_addr_q;
    assign Ret_Valid_out      = ret_valid;
    assign SP_out             = sp_q;
    assign Stack_Err_out      = err_q;

endmodule

// File: tb/tb_stage4_memory_access.sv
// Directed bench for stage4_memory_access: reset, pass-through, load/store,
// CALL/RET stack, underflow/overflow, priority and asynchronous reset.
module tb_stage4_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Result_in, data1_in;
    logic        Memory_Read_in, Memory_Write_in, Reg_Write_En_in, WB_Mux_sel_in;
    logic [4:0]  Addr_Write_Reg_in;
    logic        CALL_flag_in, RET_flag_in;
    logic [7:0]  Ret_Addr_in;
    logic [31:0] Mem_Data_out, Result_out;
    logic        Reg_Write_En_out, WB_Mux_sel_out;
    logic [4:0]  Addr_Write_Reg_out;
    logic [7:0]  Ret_Addr_out;
    logic        Ret_Valid_out;
    logic [7:0]  SP_out;
    logic        Stack_Err_out;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    stage4_memory_access #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .SP_INIT(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .Result_in(Result_in), .data1_in(data1_in),
        .Memory_Read_in(Memory_Read_in), .Memory_Write_in(Memory_Write_in),
        .Reg_Write_En_in(Reg_Write_En_in), .WB_Mux_sel_in(WB_Mux_sel_in),
        .Addr_Write_Reg_in(Addr_Write_Reg_in),
        .CALL_flag_in(CALL_flag_in), .RET_flag_in(RET_flag_in), .Ret_Addr_in(Ret_Addr_in),
        .Mem_Data_out(Mem_Data_out), .Result_out(Result_out),
        .Reg_Write_En_out(Reg_Write_En_out), .WB_Mux_sel_out(WB_Mux_sel_out),
        .Addr_Write_Reg_out(Addr_Write_Reg_out),
        .Ret_Addr_out(Ret_Addr_out), .Ret_Valid_out(Ret_Valid_out),
        .SP_out(SP_out), .Stack_Err_out(Stack_Err_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ops();
        Memory_Read_in  = 1'b0;
        Memory_Write_in = 1'b0;
        CALL_flag_in    = 1'b0;
        RET_flag_in     = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with random inputs
        reset             = 1'b0;
        Result_in         = $urandom;
        data1_in          = $urandom;
        Memory_Read_in    = 1'($urandom_range(0, 1));
        Memory_Write_in   = 1'($urandom_range(0, 1));
        Reg_Write_En_in   = 1'($urandom_range(0, 1));
        WB_Mux_sel_in     = 1'($urandom_range(0, 1));
        Addr_Write_Reg_in = 5'($urandom_range(0, 31));
        CALL_flag_in      = 1'($urandom_range(0, 1));
        RET_flag_in       = 1'($urandom_range(0, 1));
        Ret_Addr_in       = 8'($urandom_range(0, 255));
        step();
        step();
        chk("rst_mem_data", Mem_Data_out, 32'h0);
        chk("rst_result", Result_out, 32'h0);
        chk("rst_rwe", {31'h0, Reg_Write_En_out}, 32'h0);
        chk("rst_wbsel", {31'h0, WB_Mux_sel_out}, 32'h0);
        chk("rst_awr", {27'h0, Addr_Write_Reg_out}, 32'h0);
        chk("rst_ret_addr", {24'h0, Ret_Addr_out}, 32'h0);
        chk("rst_ret_valid", {31'h0, Ret_Valid_out}, 32'h0);
        chk("rst_sp", {24'h0, SP_out}, 32'hFF);
        chk("rst_err", {31'h0, Stack_Err_out}, 32'h0);

        // Pass-through
        reset = 1'b1;
        idle_ops();
        Result_in = 32'd18; WB_Mux_sel_in = 1'b0; Reg_Write_En_in = 1'b1; Addr_Write_Reg_in = 5'd7;
        step();
        chk("pt_result", Result_out, 32'd18);
        chk("pt_wbsel", {31'h0, WB_Mux_sel_out}, 32'h0);
        chk("pt_rwe", {31'h0, Reg_Write_En_out}, 32'h1);
        chk("pt_awr", {27'h0, Addr_Write_Reg_out}, 32'd7);
        chk("pt_sp", {24'h0, SP_out}, 32'hFF);

        // Store then wrapped-address load
        Result_in = 32'h0000_0012; data1_in = 32'h0000_0ABC; Memory_Write_in = 1'b1;
        WB_Mux_sel_in = 1'b1; Addr_Write_Reg_in = 5'd3;
        step();
        chk("st_result", Result_out, 32'h12);
        Memory_Write_in = 1'b0; Memory_Read_in = 1'b1; Result_in = 32'h0000_0112;
        step();
        chk("ld_data", Mem_Data_out, 32'h0000_0ABC);
        chk("ld_result", Result_out, 32'h112);
        chk("ld_wbsel", {31'h0, WB_Mux_sel_out}, 32'h1);

        // CALL 21, CALL 40, RET, RET
        idle_ops();
        CALL_flag_in = 1'b1; Ret_Addr_in = 8'h21;
        step();
        chk("call1_sp", {24'h0, SP_out}, 32'hFE);
        chk("call1_valid", {31'h0, Ret_Valid_out}, 32'h0);
        chk("call1_mem_hold", Mem_Data_out, 32'h0000_0ABC);
        Ret_Addr_in = 8'h40;
        step();
        chk("call2_sp", {24'h0, SP_out}, 32'hFD);
        CALL_flag_in = 1'b0; RET_flag_in = 1'b1;
        step();
        chk("ret1_sp", {24'h0, SP_out}, 32'hFE);
        chk("ret1_valid", {31'h0, Ret_Valid_out}, 32'h1);
        chk("ret1_addr", {24'h0, Ret_Addr_out}, 32'h40);
        chk("ret1_mem", Mem_Data_out, 32'h40);
        step();
        chk("ret2_sp", {24'h0, SP_out}, 32'hFF);
        chk("ret2_valid", {31'h0, Ret_Valid_out}, 32'h1);
        chk("ret2_addr", {24'h0, Ret_Addr_out}, 32'h21);
        chk("ret2_mem", Mem_Data_out, 32'h21);
        RET_flag_in = 1'b0;
        step();
        chk("post_ret_valid", {31'h0, Ret_Valid_out}, 32'h0);
        chk("post_ret_err", {31'h0, Stack_Err_out}, 32'h0);

        // Underflow
        RET_flag_in = 1'b1;
        step();
        chk("uf_err", {31'h0, Stack_Err_out}, 32'h1);
        chk("uf_sp", {24'h0, SP_out}, 32'hFF);
        chk("uf_valid", {31'h0, Ret_Valid_out}, 32'h1);
        chk("uf_addr", {24'h0, Ret_Addr_out}, 32'h0);

        // Priority: CALL + RET + store together only pushes
        idle_ops();
        Result_in = 32'h30; data1_in = 32'h55; Memory_Write_in = 1'b1;
        step();
        CALL_flag_in = 1'b1; RET_flag_in = 1'b1; Ret_Addr_in = 8'h33; data1_in = 32'h99;
        step();
        chk("pri_sp", {24'h0, SP_out}, 32'hFE);
        chk("pri_valid", {31'h0, Ret_Valid_out}, 32'h0);
        idle_ops();
        Memory_Read_in = 1'b1;
        step();
        chk("pri_store_blocked", Mem_Data_out, 32'h55);
        idle_ops();
        RET_flag_in = 1'b1;
        step();
        chk("pri_ret_addr", {24'h0, Ret_Addr_out}, 32'h33);
        chk("pri_ret_sp", {24'h0, SP_out}, 32'hFF);
        chk("err_sticky", {31'h0, Stack_Err_out}, 32'h1);

        // Asynchronous reset during a CALL cycle
        idle_ops();
        CALL_flag_in = 1'b1; Ret_Addr_in = 8'h10;
        step();
        chk("pre_rst_sp", {24'h0, SP_out}, 32'hFE);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_sp", {24'h0, SP_out}, 32'hFF);
        chk("async_rst_valid", {31'h0, Ret_Valid_out}, 32'h0);
        chk("async_rst_err", {31'h0, Stack_Err_out}, 32'h0);
        step();
        chk("rst_hold_sp", {24'h0, SP_out}, 32'hFF);
        reset = 1'b1;

        // Overflow: 255 pushes reach SP=0, the next wraps and flags
        for (int i = 0; i < 255; i++) begin
            Ret_Addr_in = 8'(i);
            step();
        end
        chk("ovf_sp0", {24'h0, SP_out}, 32'h0);
        chk("ovf_noerr", {31'h0, Stack_Err_out}, 32'h0);
        Ret_Addr_in = 8'hAA;
        step();
        chk("ovf_sp_wrap", {24'h0, SP_out}, 32'hFF);
        chk("ovf_err", {31'h0, Stack_Err_out}, 32'h1);
        idle_ops();
        step();
        chk("ovf_err_sticky", {31'h0, Stack_Err_out}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
